frame_decimator: RTL and testbench
==================================

FRAME_DECIMATOR -- requirements
Module: frame_decimator

Interface
REQ-001 SHALL provide parameter IMG_COL, default 1280: active pixels per line.
REQ-002 SHALL provide parameter IMG_ROW, default 720: active lines per frame.
REQ-003 SHALL provide parameter DW, default 16: pixel data width.
REQ-004 SHALL provide parameter MAX_DIV, default 4: largest decimation factor accepted.
REQ-005 Img_pclk  in  1  pixel clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 Img_vs  in  1  frame sync, active-high; its rising edge marks frame start.
REQ-008 Img_de  in  1  pixel valid; each high run is one line.
REQ-009 Img_data  in  DW  pixel data, qualified by Img_de.
REQ-010 cfg_hdiv  in  3  horizontal factor request.
REQ-011 cfg_vdiv  in  3  vertical factor request.
REQ-012 fifo_full  in  1  downstream FIFO full.
REQ-013 fifo_wr_en  out  1  registered write strobe.
REQ-014 fifo_wr_data  out  DW  registered write data.
REQ-015 frame_start  out  1  one-cycle pulse on each accepted frame start.
REQ-016 ovf_err  out  1  sticky per frame: a write was dropped because fifo_full was high.

Function
REQ-017 SHALL run a state machine with states IDLE, ACTIVE and LOCKOUT.
- IDLE: the block waits for the first Img_vs rising edge after reset and ignores Img_de.
- IDLE -> ACTIVE on that edge.
REQ-018 Vs edge detection SHALL compare Img_vs with a one-cycle registered copy.
- frame_start SHALL assert in the cycle after the edge is sampled.
REQ-019 At each accepted frame start the block SHALL:
- latch the effective hdiv/vdiv;
- clear the line index, line phase and ovf_err.
REQ-020 Effective factor: request 0 SHALL become 1; a request above MAX_DIV SHALL become MAX_DIV.
- Changes to cfg_* mid-frame SHALL have no effect until the next frame start.
REQ-021 Pixel index x and pixel phase px SHALL reset to 0 when Img_de is low.
- On each Img_de-high cycle, x SHALL increment.
- px SHALL count 0..hdiv-1 and wrap to 0.
REQ-022 On each Img_de falling edge, line index y SHALL increment.
- Line phase py SHALL count 0..vdiv-1 and wrap to 0.
REQ-023 A pixel SHALL be selected only when all of the following hold: state ACTIVE, Img_de=1, px=0, py=0, x<IMG_COL and y<IMG_ROW.
- Pixels with x>=IMG_COL or lines with y>=IMG_ROW SHALL be discarded.
REQ-024 A selected pixel with fifo_full=0 SHALL produce fifo_wr_en=1 and fifo_wr_data=Img_data exactly one cycle later (latency 1).
REQ-025 A selected pixel with fifo_full=1 SHALL be dropped and SHALL set ovf_err.
- No retry.
REQ-026 ovf_err SHALL remain 1 until the next accepted frame start or reset.
REQ-027 fifo_wr_data SHALL hold its last written value when fifo_wr_en=0.
REQ-028 ACTIVE -> LOCKOUT when y reaches IMG_ROW.
- LOCKOUT: no writes.
- LOCKOUT -> ACTIVE on the next Img_vs rising edge.
REQ-029 A Vs rising edge in ACTIVE (short frame) SHALL restart the frame per REQ-019 without error.
REQ-030 Same-cycle Vs edge and selected pixel: the frame restart SHALL take priority; that pixel SHALL NOT be written.
REQ-031 Counter widths SHALL be clog2(IMG_COL+1) for x and clog2(IMG_ROW+1) for y; they SHALL saturate, not wrap.

Reset
REQ-032 While rst_n=0 at a clock edge, the block SHALL:
- enter IDLE;
- clear fifo_wr_en, fifo_wr_data, frame_start, ovf_err and all counters;
- set the latched factors to 1.
REQ-033 Reset asserted mid-frame SHALL abort the frame; no write SHALL occur in the cycle after reset is sampled.
REQ-034 After reset release, output SHALL resume only after a new Img_vs rising edge.

Verification
REQ-035 The bench SHALL cover the following directed scenarios (IMG_COL=8, IMG_ROW=4):
- hdiv=2, vdiv=2, 4 lines of data 0..31 -> 8 writes: 0,2,4,6,16,18,20,22.
- hdiv=3, vdiv=1 -> per line, writes of x=0,3,6; 12 writes total.
- cfg 0/7 with MAX_DIV=4 -> factor 1 horizontal and 4 vertical; 8 writes (line 0 only).
- fifo_full=1 during pixel x=2 of line 0, hdiv=vdiv=2 -> write dropped, ovf_err=1 to end of frame, 0 after next frame_start.
- Lines of 10 DE cycles and 6 lines -> x>=8 and y>=4 pixels not written; state LOCKOUT until Img_vs rises.
- Reset pulsed mid-line -> fifo_wr_en=0 next cycle; no writes until the following Img_vs edge and frame_start pulse.

Source files
------------

// File: rtl/frame_decimator.sv
// frame_decimator: picks every hdiv-th pixel of every vdiv-th line inside the
// IMG_COL x IMG_ROW active window and forwards it to a downstream FIFO with a
// one-cycle registered write. Factors are sampled once per frame on Img_vs.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | after reset, waiting for the first Img_vs rising edge
// ACTIVE  | inside a frame, selecting and writing pixels
// LOCKOUT | IMG_ROW lines done, ignoring Img_de until the next Img_vs edge
module frame_decimator #(
    parameter int IMG_COL = 1280,
    parameter int IMG_ROW = 720,
    parameter int DW      = 16,
    parameter int MAX_DIV = 4
) (
    input  logic          Img_pclk,
    input  logic          rst_n,
    input  logic          Img_vs,
    input  logic          Img_de,
    input  logic [DW-1:0] Img_data,
    input  logic [2:0]    cfg_hdiv,
    input  logic [2:0]    cfg_vdiv,
    input  logic          fifo_full,
    output logic          fifo_wr_en,
    output logic [DW-1:0] fifo_wr_data,
    output logic          frame_start,
    output logic          ovf_err
);

    localparam int XW = $clog2(IMG_COL + 1);
    localparam int YW = $clog2(IMG_ROW + 1);
    localparam logic [XW-1:0] X_END   = XW'(IMG_COL);
    localparam logic [YW-1:0] Y_END   = YW'(IMG_ROW);
    localparam logic [2:0]    DIV_CAP = 3'(MAX_DIV);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            vs_d;
    logic            de_d;
    logic            vs_rise;
    logic            de_fall;
    logic            pix_sel;
    logic [XW-1:0]   x_q;
    logic [2:0]      px_q;
    logic [YW-1:0]   y_q;
    logic [2:0]      py_q;
    logic [2:0]      hdiv_q;
    logic [2:0]      vdiv_q;

    // A request of 0 means "no decimation"; anything above the cap is clipped.
    function automatic logic [2:0] clamp_div(input logic [2:0] req);
        if (req == 3'd0) begin
            return 3'd1;
        end else if (req > DIV_CAP) begin
            return DIV_CAP;
        end else begin
            return req;
        end
    endfunction

    assign vs_rise = Img_vs & ~vs_d;
    assign de_fall = ~Img_de & de_d;

    // Delayed copies of Img_vs / Img_de for edge detection. Loading Img_vs
    // during reset keeps a sync that is already high from counting as an edge.
    always_ff @(posedge Img_pclk) begin
        if (!rst_n) begin
            vs_d <= Img_vs;
            de_d <= 1'b0;
        end else begin
            vs_d <= Img_vs;
            de_d <= Img_de;
        end
    end

    // State register.
    always_ff @(posedge Img_pclk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and pixel selection; a frame restart always wins over a pixel.
    always_comb begin
        state_d = state_q;
        pix_sel = 1'b0;
        case (state_q)
            IDLE: begin
                if (vs_rise) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    state_d = ACTIVE;
                end else if (y_q == Y_END) begin
                    state_d = LOCKOUT;
                end else begin
                    pix_sel = Img_de && (px_q == 3'd0) && (py_q == 3'd0) &&
                              (x_q < X_END) && (y_q < Y_END);
                end
            end
            LOCKOUT: begin
                if (vs_rise) begin
                    state_d = ACTIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pixel/line position and phase counters plus the per-frame factor latch.
    always_ff @(posedge Img_pclk) begin
        if (!rst_n) begin
            x_q    <= '0;
            px_q   <= 3'd0;
            y_q    <= '0;
            py_q   <= 3'd0;
            hdiv_q <= 3'd1;
            vdiv_q <= 3'd1;
        end else begin
            if (Img_de) begin
                x_q  <= (x_q == X_END) ? x_q : x_q + XW'(1);
                px_q <= (px_q >= hdiv_q - 3'd1) ? 3'd0 : px_q + 3'd1;
            end else begin
                x_q  <= '0;
                px_q <= 3'd0;
            end
            if (vs_rise) begin
                y_q    <= '0;
                py_q   <= 3'd0;
                hdiv_q <= clamp_div(cfg_hdiv);
                vdiv_q <= clamp_div(cfg_vdiv);
            end else if (de_fall) begin
                y_q  <= (y_q == Y_END) ? y_q : y_q + YW'(1);
                py_q <= (py_q >= vdiv_q - 3'd1) ? 3'd0 : py_q + 3'd1;
            end
        end
    end

    // Registered FIFO write, frame_start pulse and sticky overflow flag.
    always_ff @(posedge Img_pclk) begin
        if (!rst_n) begin
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            frame_start  <= 1'b0;
            ovf_err      <= 1'b0;
        end else begin
            frame_start <= vs_rise;
            fifo_wr_en  <= pix_sel & ~fifo_full;
            if (pix_sel && !fifo_full) begin
                fifo_wr_data <= Img_data;
            end
            if (vs_rise) begin
                ovf_err <= 1'b0;
            end else if (pix_sel && fifo_full) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_decimator.sv
// Testbench for frame_decimator: directed frames plus randomized frames,
// with expected writes derived from window/modulo rules per line and pixel.
module tb_frame_decimator;

    localparam int IMG_COL = 8;
    localparam int IMG_ROW = 4;
    localparam int DW      = 16;
    localparam int MAX_DIV = 4;

    logic          Img_pclk = 1'b0;
    logic          rst_n;
    logic          Img_vs;
    logic          Img_de;
    logic [DW-1:0] Img_data;
    logic [2:0]    cfg_hdiv;
    logic [2:0]    cfg_vdiv;
    logic          fifo_full;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wr_data;
    logic          frame_start;
    logic          ovf_err;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] act_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] want_q[$];
    bit            exp_ovf;
    int            he;
    int            ve;

    frame_decimator #(
        .IMG_COL (IMG_COL),
        .IMG_ROW (IMG_ROW),
        .DW      (DW),
        .MAX_DIV (MAX_DIV)
    ) dut (
        .Img_pclk     (Img_pclk),
        .rst_n        (rst_n),
        .Img_vs       (Img_vs),
        .Img_de       (Img_de),
        .Img_data     (Img_data),
        .cfg_hdiv     (cfg_hdiv),
        .cfg_vdiv     (cfg_vdiv),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .frame_start  (frame_start),
        .ovf_err      (ovf_err)
    );

    always #5 Img_pclk = ~Img_pclk;

    // Record every FIFO write, sampled on the falling edge.
    always @(negedge Img_pclk) begin
        if (fifo_wr_en === 1'b1) act_q.push_back(fifo_wr_data);
    end

    task automatic tick();
        @(negedge Img_pclk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int eff(input int r);
        if (r == 0) return 1;
        if (r > MAX_DIV) return MAX_DIV;
        return r;
    endfunction

    // Vs pulse with the frame_start/ovf_err checks; cfg then scrambled mid-frame.
    task automatic start_frame(input int h, input int v);
        tick();
        Img_vs = 1'b1; Img_de = 1'b0; fifo_full = 1'b0;
        cfg_hdiv = 3'(h); cfg_vdiv = 3'(v);
        act_q.delete(); exp_q.delete(); exp_ovf = 1'b0;
        he = eff(h); ve = eff(v);
        tick();
        chk("fs_pulse", {31'd0, frame_start}, 32'd1);
        chk("ovf_clr", {31'd0, ovf_err}, 32'd0);
        Img_vs = 1'b0;
        cfg_hdiv = 3'($urandom_range(0, 7));
        cfg_vdiv = 3'($urandom_range(0, 7));
        tick();
        chk("fs_width", {31'd0, frame_start}, 32'd0);
    endtask

    // fmode: 0 never full, 1 random full, 2 full only at line 0 pixel 2.
    task automatic run_lines(input int l0, input int nlines, input int llen,
                             input bit seq, input int fmode);
        for (int l = l0; l < l0 + nlines; l++) begin
            for (int i = 0; i < llen; i++) begin
                logic [DW-1:0] d;
                bit            full;
                bit            sel;
                tick();
                d = seq ? DW'(l * llen + i) : DW'($urandom);
                full = 1'b0;
                if (fmode == 1) full = ($urandom_range(0, 3) == 0);
                if (fmode == 2) full = (l == 0 && i == 2);
                Img_de = 1'b1; Img_data = d; fifo_full = full;
                sel = (l < IMG_ROW) && (i < IMG_COL) && (i % he == 0) && (l % ve == 0);
                if (sel && !full) exp_q.push_back(d);
                if (sel && full) exp_ovf = 1'b1;
            end
            repeat (2) begin
                tick();
                Img_de = 1'b0; fifo_full = 1'b0;
            end
        end
        repeat (2) tick();
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            chk({tag, "_data"}, {16'd0, act_q[i]}, {16'd0, exp_q[i]});
        chk({tag, "_ovf"}, {31'd0, ovf_err}, {31'd0, exp_ovf});
        if (exp_q.size() > 0)
            chk({tag, "_hold"}, {16'd0, fifo_wr_data}, {16'd0, exp_q[$]});
    endtask

    task automatic check_list(input string tag);
        chk({tag, "_lcount"}, act_q.size(), want_q.size());
        for (int i = 0; i < act_q.size() && i < want_q.size(); i++)
            chk({tag, "_ldata"}, {16'd0, act_q[i]}, {16'd0, want_q[i]});
    endtask

    initial begin
        rst_n = 1'b0; Img_vs = 1'b0; Img_de = 1'b0; Img_data = '0;
        cfg_hdiv = 3'd1; cfg_vdiv = 3'd1; fifo_full = 1'b0;
        he = 1; ve = 1; exp_ovf = 1'b0;
        repeat (3) tick();
        chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        chk("rst_wr_data", {16'd0, fifo_wr_data}, 32'd0);
        chk("rst_fs", {31'd0, frame_start}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_err}, 32'd0);
        rst_n = 1'b1;

        // Data before any frame sync must be ignored.
        repeat (2) begin
            repeat (6) begin tick(); Img_de = 1'b1; Img_data = DW'($urandom); end
            repeat (2) begin tick(); Img_de = 1'b0; end
        end
        repeat (2) tick();
        chk("idle_nowr", act_q.size(), 32'd0);

        // hdiv=2, vdiv=2 on sequential data.
        start_frame(2, 2);
        run_lines(0, 4, 8, 1'b1, 0);
        want_q = '{16'd0, 16'd2, 16'd4, 16'd6, 16'd16, 16'd18, 16'd20, 16'd22};
        check_list("d22");
        check_frame("d22");

        // hdiv=3, vdiv=1.
        start_frame(3, 1);
        run_lines(0, 4, 8, 1'b1, 0);
        want_q = '{16'd0, 16'd3, 16'd6, 16'd8, 16'd11, 16'd14,
                   16'd16, 16'd19, 16'd22, 16'd24, 16'd27, 16'd30};
        check_list("d31");
        check_frame("d31");

        // Requests 0/7 clamp to 1 and MAX_DIV.
        start_frame(0, 7);
        run_lines(0, 4, 8, 1'b1, 0);
        want_q = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
        check_list("clamp");
        check_frame("clamp");

        // FIFO full on line 0 pixel 2: dropped, sticky overflow.
        start_frame(2, 2);
        run_lines(0, 4, 8, 1'b1, 2);
        want_q = '{16'd0, 16'd4, 16'd6, 16'd16, 16'd18, 16'd20, 16'd22};
        check_list("ovf");
        check_frame("ovf");
        chk("ovf_sticky", {31'd0, ovf_err}, 32'd1);

        // Oversized frame: window clipping, then lockout until next Vs.
        start_frame(1, 1);
        run_lines(0, 6, 10, 1'b1, 0);
        check_frame("clip");
        act_q.delete(); exp_q.delete();
        run_lines(6, 2, 5, 1'b0, 0);
        check_frame("lockout");
        start_frame(1, 1);
        run_lines(0, 1, 4, 1'b0, 0);
        check_frame("unlock");

        // Vs edge coinciding with a selectable pixel: restart wins.
        start_frame(1, 1);
        tick();
        Img_de = 1'b1; Img_data = 16'hA5A5;
        exp_q.push_back(16'hA5A5);
        tick();
        Img_vs = 1'b1; cfg_hdiv = 3'd1; cfg_vdiv = 3'd1; Img_data = 16'h5A5A;
        tick();
        chk("fs_restart", {31'd0, frame_start}, 32'd1);
        Img_vs = 1'b0; Img_de = 1'b0;
        he = 1; ve = 1;
        run_lines(1, 4, 2, 1'b0, 0);
        check_frame("restart");

        // Reset in the middle of a line.
        start_frame(1, 1);
        tick();
        Img_de = 1'b1; Img_data = 16'h1111;
        tick();
        Img_data = 16'h2222; rst_n = 1'b0;
        tick();
        chk("midrst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        chk("midrst_wr_data", {16'd0, fifo_wr_data}, 32'd0);
        chk("midrst_ovf", {31'd0, ovf_err}, 32'd0);
        rst_n = 1'b1;
        act_q.delete();
        repeat (3) begin tick(); Img_de = 1'b1; Img_data = DW'($urandom); end
        repeat (2) begin tick(); Img_de = 1'b0; end
        repeat (5) begin tick(); Img_de = 1'b1; Img_data = DW'($urandom); end
        repeat (3) begin tick(); Img_de = 1'b0; end
        chk("postrst_nowr", act_q.size(), 32'd0);
        start_frame(2, 1);
        run_lines(0, 2, 4, 1'b0, 0);
        check_frame("postrst");

        // Randomized frames with random fifo_full back-pressure.
        for (int f = 0; f < 10; f++) begin
            start_frame($urandom_range(0, 7), $urandom_range(0, 7));
            run_lines(0, $urandom_range(1, 6), $urandom_range(1, 10), 1'b0, 1);
            check_frame("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
